triangle_assembler: RTL
=======================

// Module: triangle_assembler
// PURPOSE
// - Consumes the per-cycle vertex stream from sprite_creator (vertex/color/new_triangle/active) and packs
//   every 3 consecutive vertices into one triangle record {v0,v1,v2,color}.
// - Buffers records in a FIFO; presents them to the projection/raster stage over a valid/ready handshake.
// - Absorbs the bursty, non-stallable upstream stream. Upstream has no ready signal.
// PARAMETERS
// - FIFO_DEPTH   8   triangle records buffered; power of 2, >=2
// - CNT_W        8   width of drop_count / cull_count (saturating)
// PORTS
// - clk             in   1    clock
// - rst             in   1    reset, synchronous, active-high
// - vertex_in       in   48   {x[47:32], y[31:16], z[15:0]}, signed 16b each
// - color_in        in   16   triangle color; sampled only with the first vertex
// - new_triangle_in in   1    high on the cycle carrying a triangle's first vertex
// - active_in       in   1    upstream emitting; a vertex is present only while high
// - tri_valid       out  1    output record valid
// - tri_ready       in   1    downstream accepts the record when tri_valid & tri_ready
// - tri_v0/v1/v2    out  48   vertices, in arrival order
// - tri_color       out  16   color of record
// - fifo_count      out  $clog2(FIFO_DEPTH)+1  stored records
// - busy            out  1    partial triangle in progress OR fifo_count!=0
// - overflow        out  1    sticky; set on any dropped complete triangle
// - drop_count      out  CNT_W  saturating count of triangles dropped on a full FIFO
// BEHAVIOUR
// - Reset: all outputs 0, FIFO emptied, assembler to WAIT0, counters 0, overflow 0.
// - Vertex accept = active_in & (new_triangle_in | state!=WAIT0). Accept by state:
//   WAIT0: accept only on new_triangle_in; latch v0 and color_in -> GOT1. active_in high with
//     new_triangle_in low is ignored (covers the upstream lead-in cycle).
//   GOT1: latch v1 -> GOT2.   GOT2: latch v2, push record -> WAIT0.
// - new_triangle_in high in GOT1/GOT2: discard partial; restart with this vertex as v0 (-> GOT1).
// - active_in low in GOT1/GOT2: discard partial -> WAIT0. No record is pushed.
// - Push happens on the GOT2 accept cycle. Record is visible at the output the next cycle:
//   latency 1 clk from third vertex to tri_valid when the FIFO is empty.
// - FIFO is show-ahead. tri_* hold stable while tri_valid & !tri_ready.
// - Pop only on tri_valid & tri_ready.
// - Full FIFO on a push: if a pop occurs in the same cycle, the push succeeds. Otherwise the record
//   is dropped, overflow<=1, and drop_count increments, saturating at all-ones.
// - Push and pop in the same cycle on an empty FIFO: no bypass. Record valid next cycle.
// - Pointers wrap modulo FIFO_DEPTH. fifo_count is exact and never exceeds FIFO_DEPTH.
// - rst mid-triangle or with a non-empty FIFO: contents discarded, tri_valid 0 the next cycle.
// - No arithmetic on coordinates. Vertices pass through bit-exact.
// CONFIGURATION
// - DEGENERATE_CULL_EN defined: at the push cycle, a triangle is culled and not pushed when v0==v1,
//   v1==v2, or v0==v2 (full 48b compare).
//   - Adds output cull_count[CNT_W-1:0], saturating, reset 0.
//   - A culled triangle never counts as a drop and never sets overflow.
// - DEGENERATE_CULL_EN undefined: all complete triangles are pushed. cull_count port absent.
// TESTING
// - Full sprite burst: 1 lead-in cycle (active=1, nt=0), then 30 vertices with nt every 3rd; tri_ready=1
//   -> exactly 10 records, each 1 clk after its 3rd vertex, vertices and color bit-exact,
//   overflow=0.
// - Same burst, tri_ready=0, FIFO_DEPTH=8 -> fifo_count=8, drop_count=2, overflow=1. Then raise tri_ready
//   -> first 8 triangles drain in order, fifo_count ends at 0.
// - Restart: nt at v0, vertex, nt again, 2 more vertices -> one record whose v0 is the second nt vertex.
// - Abort: nt, 1 vertex, active_in=0 for 1 cycle, then a clean triangle -> only the clean triangle is output.
// - FIFO full, tri_ready=1 on the push cycle -> no drop, fifo_count stays 8, drop_count unchanged.
// - DEGENERATE_CULL_EN: triangle (1,2,3),(1,2,3),(4,5,6) -> not output, cull_count=1.
//   rst mid-burst -> tri_valid=0 and fifo_count=0 the next cycle.

Source files
------------

// File: rtl/triangle_assembler.sv
// triangle_assembler
//   Packs the per-cycle vertex stream from sprite_creator into triangle
//   records {v0,v1,v2,color}. Records are buffered in a show-ahead FIFO and
//   handed to the projection/raster stage over a valid/ready handshake.
//   Upstream has no ready signal, so a complete triangle that meets a full
//   FIFO is dropped and counted.
//
// Optional build macro: DEGENERATE_CULL_EN
//   When defined, a triangle with any two identical vertices (full 48-bit
//   compare) is culled at the push cycle instead of being stored. This adds
//   the cull_count output.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   vertex_in[47:0]     {x,y,z}, signed 16b each, passed through bit-exact
//   color_in[15:0]      triangle color, sampled with the first vertex
//   new_triangle_in     marks a triangle's first vertex
//   active_in           a vertex is present only while high
//   tri_valid/tri_ready output handshake
//   tri_v0/v1/v2        vertices in arrival order
//   tri_color           record color
//   fifo_count          records stored
//   busy                partial triangle in progress or FIFO non-empty
//   overflow            sticky, set when a complete triangle is dropped
//   drop_count          saturating count of dropped triangles
//   cull_count          saturating count of culled triangles (macro only)
module triangle_assembler #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [47:0]                   vertex_in,
  input  logic [15:0]                   color_in,
  input  logic                          new_triangle_in,
  input  logic                          active_in,
  output logic                          tri_valid,
  input  logic                          tri_ready,
  output logic [47:0]                   tri_v0,
  output logic [47:0]                   tri_v1,
  output logic [47:0]                   tri_v2,
  output logic [15:0]                   tri_color,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow,
`ifdef DEGENERATE_CULL_EN
  output logic [CNT_W-1:0]              cull_count,
`endif
  output logic [CNT_W-1:0]              drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 3 * 48 + 16;

  typedef enum logic [1:0] {WAIT0, GOT1, GOT2} state_t;

  state_t state, state_nxt;
  logic   ld_v0, ld_v1, tri_done;

  logic [47:0] v0_p1, v1_p1;
  logic [15:0] color_p1;

  logic              push_req, push_ok, pop, full;
  logic [REC_W-1:0]  rec_in, rd_rec;
  logic [REC_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Stage 0: vertex acceptance. new_triangle_in always restarts, active_in
  // low always abandons a partial triangle.
  always_comb begin
    state_nxt = state;
    ld_v0     = 1'b0;
    ld_v1     = 1'b0;
    tri_done  = 1'b0;
    case (state)
      WAIT0: begin
        if (active_in && new_triangle_in) begin
          ld_v0     = 1'b1;
          state_nxt = GOT1;
        end
      end
      GOT1: begin
        if (!active_in) begin
          state_nxt = WAIT0;
        end else if (new_triangle_in) begin
          ld_v0     = 1'b1;
          state_nxt = GOT1;
        end else begin
          ld_v1     = 1'b1;
          state_nxt = GOT2;
        end
      end
      GOT2: begin
        if (!active_in) begin
          state_nxt = WAIT0;
        end else if (new_triangle_in) begin
          ld_v0     = 1'b1;
          state_nxt = GOT1;
        end else begin
          tri_done  = 1'b1;
          state_nxt = WAIT0;
        end
      end
      default: state_nxt = WAIT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT0;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (ld_v0) begin
      v0_p1    <= vertex_in;
      color_p1 <= color_in;
    end
    if (ld_v1) v1_p1 <= vertex_in;
  end

  // Stage 1: the third vertex goes straight from the input into the record.
  assign rec_in = {v0_p1, v1_p1, vertex_in, color_p1};

`ifdef DEGENERATE_CULL_EN
  logic degenerate;
  assign degenerate = (v0_p1 == v1_p1) || (v1_p1 == vertex_in) || (v0_p1 == vertex_in);
  assign push_req   = tri_done && !degenerate;

  always_ff @(posedge clk) begin
    if (rst)                      cull_count <= '0;
    else if (tri_done && degenerate) cull_count <= sat_inc(cull_count);
  end
`else
  assign push_req = tri_done;
`endif

  // A full FIFO still takes the push when the head leaves in the same cycle;
  // the slot being written is the one being vacated.
  assign tri_valid = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = tri_valid && tri_ready;
  assign push_ok   = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  // Stage 2: show-ahead head of FIFO, forced to zero while empty so the
  // outputs read 0 out of reset without clearing the storage array.
  assign rd_rec     = mem[rd_ptr];
  assign tri_v0     = tri_valid ? rd_rec[159:112] : '0;
  assign tri_v1     = tri_valid ? rd_rec[111:64]  : '0;
  assign tri_v2     = tri_valid ? rd_rec[63:16]   : '0;
  assign tri_color  = tri_valid ? rd_rec[15:0]    : '0;
  assign fifo_count = count;
  assign busy       = (state != WAIT0) || tri_valid;

endmodule
